// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX-stage decode and the RV32M sequencer.
// The master side (pipeline) drives the request and the flush; the slave side
// (sequencer) returns busy/stall/done and the 32-bit result.
interface muldiv_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, rs1, rs2, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execution controller. One request at a time: a registered
// 32x32 multiply (one cycle) or a 32-iteration restoring divide on operand
// magnitudes followed by a sign-fix cycle. Division special cases (divide by
// zero, signed overflow) bypass the iteration and resolve in the fix cycle.
module muldiv_sequencer (
  input  logic            clk,
  input  logic            rst,
  muldiv_sequencer_if.slave bus
);

  // func3 encodings of the M extension
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e      state_q,   state_d;
  logic [2:0]  op_q,      op_d;
  logic [31:0] a_q,       a_d;
  logic [31:0] b_q,       b_d;
  logic [31:0] divisor_q, divisor_d;
  logic [32:0] rem_q,     rem_d;
  logic [31:0] quo_q,     quo_d;
  logic [4:0]  cnt_q,     cnt_d;
  logic        special_q, special_d;
  logic [31:0] result_q,  result_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;

  // accept-time decode of the incoming request
  logic        acc_signed_div_s;
  logic        acc_div0_s;
  logic        acc_ovf_s;
  logic [31:0] acc_dividend_s;
  logic [31:0] acc_divisor_s;

  // datapath results consumed by the FSM
  logic [63:0] mul_a_s;
  logic [63:0] mul_b_s;
  logic [63:0] prod_s;
  logic [31:0] mul_res_s;
  logic [33:0] trial_s;
  logic [31:0] fix_res_s;
  logic        fix_signed_s;

  // two's complement negation of a 32-bit word
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Decode division operand magnitudes and special cases for the request on the bus
  always_comb begin
    acc_signed_div_s = bus.op[2] & ~bus.op[0];
    acc_div0_s       = (bus.rs2 == 32'd0);
    acc_ovf_s        = acc_signed_div_s & (bus.rs1 == 32'h8000_0000) &
                       (bus.rs2 == 32'hFFFF_FFFF);
    if (acc_signed_div_s && bus.rs1[31]) begin
      acc_dividend_s = neg32(bus.rs1);
    end else begin
      acc_dividend_s = bus.rs1;
    end
    if (acc_signed_div_s && bus.rs2[31]) begin
      acc_divisor_s = neg32(bus.rs2);
    end else begin
      acc_divisor_s = bus.rs2;
    end
  end

  // 64-bit product with per-op operand signedness; selects low or high half
  always_comb begin
    // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed
    if (op_q[1:0] != 2'b11) begin
      mul_a_s = {{32{a_q[31]}}, a_q};
    end else begin
      mul_a_s = {32'd0, a_q};
    end
    if (op_q[1] == 1'b0) begin
      mul_b_s = {{32{b_q[31]}}, b_q};
    end else begin
      mul_b_s = {32'd0, b_q};
    end
    prod_s = mul_a_s * mul_b_s;
    case (op_q)
      OP_MUL:    mul_res_s = prod_s[31:0];
      OP_MULH:   mul_res_s = prod_s[63:32];
      OP_MULHSU: mul_res_s = prod_s[63:32];
      OP_MULHU:  mul_res_s = prod_s[63:32];
      default:   mul_res_s = prod_s[31:0];
    endcase
  end

  // One restoring-division step: trial subtract of the divisor from the shifted remainder
  always_comb begin
    trial_s = {rem_q, quo_q[31]} - {2'b00, divisor_q};
  end

  // Final divide result: special-case constants or sign-fixed quotient/remainder
  always_comb begin
    fix_signed_s = ~op_q[0];
    if (special_q) begin
      if (b_q == 32'd0) begin
        // divide by zero: all-ones quotient, remainder is the dividend
        if (op_q[1]) begin
          fix_res_s = a_q;
        end else begin
          fix_res_s = 32'hFFFF_FFFF;
        end
      end else begin
        // signed overflow: quotient wraps to the dividend, remainder is zero
        if (op_q[1]) begin
          fix_res_s = 32'd0;
        end else begin
          fix_res_s = 32'h8000_0000;
        end
      end
    end else if (op_q[1]) begin
      // remainder follows the sign of the dividend
      if (fix_signed_s && a_q[31]) begin
        fix_res_s = neg32(rem_q[31:0]);
      end else begin
        fix_res_s = rem_q[31:0];
      end
    end else begin
      // quotient is negative when operand signs differ
      if (fix_signed_s && (a_q[31] != b_q[31])) begin
        fix_res_s = neg32(quo_q);
      end else begin
        fix_res_s = quo_q;
      end
    end
  end

  // Sequencer next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    special_d = special_q;
    result_d  = result_q;

    if (bus.flush) begin
      // squash: drop whatever is in flight, result left untouched
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_d = bus.op;
            a_d  = bus.rs1;
            b_d  = bus.rs2;
            if (bus.op[2] == 1'b0) begin
              state_d = ST_MUL;
            end else begin
              rem_d     = 33'd0;
              quo_d     = acc_dividend_s;
              divisor_d = acc_divisor_s;
              cnt_d     = 5'd31;
              if (acc_div0_s || acc_ovf_s) begin
                special_d = 1'b1;
                state_d   = ST_FIX;
              end else begin
                special_d = 1'b0;
                state_d   = ST_DIV;
              end
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          result_d = mul_res_s;
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          if (trial_s[33] == 1'b0) begin
            rem_d = trial_s[32:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = {rem_q[31:0], quo_q[31]};
            quo_d = {quo_q[30:0], 1'b0};
          end
          if (cnt_q == 5'd0) begin
            state_d = ST_FIX;
          end else begin
            cnt_d   = cnt_q - 5'd1;
            state_d = ST_DIV;
          end
        end
        ST_FIX: begin
          result_d = fix_res_s;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      divisor_q <= 32'd0;
      rem_q     <= 33'd0;
      quo_q     <= 32'd0;
      cnt_q     <= 5'd0;
      special_q <= 1'b0;
      result_q  <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  // stall rises with an acceptable request and drops in the done cycle
  assign bus.stall  = (bus.start & (state_q == ST_IDLE) & ~bus.flush) |
                      (busy_q & (state_q != ST_DONE));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed test-plan cases, randomized
// operations against an arithmetic reference model, start-while-busy, flush and reset.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if mif ();

  muldiv_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference result from the RV32M arithmetic rules
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint    p;
    int        sa;
    int        sb;
    logic [31:0] r;
    logic      ovf;
    sa  = int'(a);
    sb  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); r = p[31:0];  end
      3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'(b);  r = p[63:32]; end
      3'd3: begin p = longint'(a)  * longint'(b);  r = p[63:32]; end
      3'd4: r = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Cycles from accept to done
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 32'd0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Issue one op in cycle N and check stall/done/busy/result each cycle through done
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int          lat;
    logic [31:0] exp;
    exp = ref_result(op, a, b);
    lat = ref_latency(op, a, b);
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = op;
    mif.rs1   = a;
    mif.rs2   = b;
    #1;
    chk({tag, " stall@N"}, 32'(mif.stall), 32'd1);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      mif.start = 1'b0;
      mif.rs1   = $urandom;     // operands must have been latched at accept
      mif.rs2   = $urandom;
      #1;
      if (i < lat) begin
        chk({tag, " done_early"}, 32'(mif.done), 32'd0);
        chk({tag, " stall_busy"}, 32'(mif.stall), 32'd1);
      end else begin
        chk({tag, " done"}, 32'(mif.done), 32'd1);
        chk({tag, " stall_done"}, 32'(mif.stall), 32'd0);
        chk({tag, " busy_done"}, 32'(mif.busy), 32'd1);
        chk({tag, " result"}, mif.result, exp);
      end
    end
    @(negedge clk);
    #1;
    chk({tag, " idle_busy"}, 32'(mif.busy), 32'd0);
    chk({tag, " idle_done"}, 32'(mif.done), 32'd0);
    chk({tag, " held_result"}, mif.result, exp);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst       = 1'b1;
    mif.start = 1'b0;
    mif.op    = 3'd0;
    mif.rs1   = 32'd0;
    mif.rs2   = 32'd0;
    mif.flush = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst busy", 32'(mif.busy), 32'd0);
    chk("rst done", 32'(mif.done), 32'd0);
    chk("rst result", mif.result, 32'd0);
    chk("rst stall", 32'(mif.stall), 32'd0);
    rst = 1'b0;

    // directed test-plan operations
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mul");
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mulh");
    run_op(3'd3, 32'hFFFF_FFFE, 32'd3, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");
    run_op(3'd5, 32'd5, 32'd0, "divu0");
    run_op(3'd6, 32'd5, 32'd0, "rem0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // randomized operations against the reference model
    for (int k = 0; k < 24; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = ~32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, "rand");
    end

    // start with new operands during a divide is ignored
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd5; mif.rs1 = 32'd100; mif.rs2 = 32'd7;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (i == 10) begin
        mif.start = 1'b1; mif.op = 3'd0; mif.rs1 = 32'd5; mif.rs2 = 32'd5;
      end else begin
        mif.start = 1'b0;
      end
      #1;
      if (i < 34) begin
        chk("busystart done_early", 32'(mif.done), 32'd0);
      end else begin
        chk("busystart done", 32'(mif.done), 32'd1);
        chk("busystart result", mif.result, 32'd14);
      end
    end
    @(negedge clk);
    #1;
    chk("busystart idle", 32'(mif.busy), 32'd0);
    run_op(3'd0, 32'd5, 32'd5, "after_busystart");

    // flush in the middle of a divide
    run_op(3'd0, 32'd6, 32'd7, "pre_flush");
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd5; mif.rs1 = 32'd1000; mif.rs2 = 32'd3;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      mif.start = 1'b0;
      #1;
      chk("flush no_done", 32'(mif.done), 32'd0);
    end
    mif.flush = 1'b1;
    @(negedge clk);
    mif.flush = 1'b0;
    #1;
    chk("flush busy", 32'(mif.busy), 32'd0);
    chk("flush done", 32'(mif.done), 32'd0);
    chk("flush stall", 32'(mif.stall), 32'd0);
    chk("flush result", mif.result, 32'd42);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("flush late_done", 32'(mif.done), 32'd0);
    end
    run_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "after_flush");

    // reset in the middle of a divide
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd4; mif.rs1 = 32'hFFFF_FFF9; mif.rs2 = 32'd2;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      mif.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst busy", 32'(mif.busy), 32'd0);
    chk("midrst done", 32'(mif.done), 32'd0);
    chk("midrst result", mif.result, 32'd0);
    chk("midrst stall", 32'(mif.stall), 32'd0);
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      #1;
      chk("midrst late_done", 32'(mif.done), 32'd0);
    end

    // reset together with start: no accept
    @(negedge clk);
    rst = 1'b1;
    mif.start = 1'b1; mif.op = 3'd0; mif.rs1 = 32'd9; mif.rs2 = 32'd9;
    @(negedge clk);
    rst = 1'b0;
    mif.start = 1'b0;
    #1;
    chk("rststart busy", 32'(mif.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rststart done", 32'(mif.done), 32'd0);
      chk("rststart result", mif.result, 32'd0);
    end
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1234, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
